// File: rtl/fpga_exp2_tdm_mux.sv
// fpga_exp2_tdm_mux
//   Eight-channel time-division multiplexer. Arbitrates among eight 4-bit
//   sources and places one granted word at a time on a shared 4-bit bus,
//   tagged with its 3-bit channel index. The dout/cs pair feeds the EXP2
//   1-to-8 demultiplexer's data4/cs inputs directly.
//
// Parameters
//   HOLD        cycles each granted word stays on the bus (1..15)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          global enable; new grants only while high
//   req[7:0]    per-channel request levels
//   din0..din7  channel data, sampled at the grant edge only
//   dout[3:0]   registered multiplexed word
//   cs[2:0]     registered channel index of dout
//   valid       high while dout/cs carry a granted word
//   ack[7:0]    one-hot, one-cycle grant pulse
//
// Build option
//   TDM_MUX_RR_EN  defined   : round-robin grant scanning upward from ptr
//                  undefined : fixed priority, lowest set req bit wins
module fpga_exp2_tdm_mux #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [3:0] din0,
  input  logic [3:0] din1,
  input  logic [3:0] din2,
  input  logic [3:0] din3,
  input  logic [3:0] din4,
  input  logic [3:0] din5,
  input  logic [3:0] din6,
  input  logic [3:0] din7,
  output logic [3:0] dout,
  output logic [2:0] cs,
  output logic       valid,
  output logic [7:0] ack
);

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 4;

  // cnt is loaded with HOLD-1 so valid stays up for exactly HOLD cycles.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic [NUM_LANES-1:0][VEC_W-1:0] din_arr;
  assign din_arr = {din7, din6, din5, din4, din3, din2, din1, din0};

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q,   cnt_d;
  logic [VEC_W-1:0]       dout_q,  dout_d;
  logic [2:0]             cs_q,    cs_d;
  logic                   valid_q, valid_d;
  logic [NUM_LANES-1:0]   ack_q,   ack_d;

  // Lower bound of the upward scan. With fixed priority it is tied to 0,
  // so the "upper" request set is simply req.
  logic [2:0] scan_base;
`ifdef TDM_MUX_RR_EN
  logic [2:0] ptr_q, ptr_d;
  assign scan_base = ptr_q;
`else
  assign scan_base = 3'd0;
`endif

  // Requests at or above the scan base; a hit here wins before wrapping.
  logic [NUM_LANES-1:0] hi_req;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fpga_exp2_tdm_mux_lane #(.IDX(i)) u_lane (
      .req_i (req[i]),
      .ptr_i (scan_base),
      .hi_o  (hi_req[i])
    );
  end

  function automatic logic [2:0] lowest(input logic [NUM_LANES-1:0] v);
    lowest = 3'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (v[i]) lowest = 3'(i);
  endfunction

  // Nothing at/above the base means the scan wraps past 7 into the low lanes.
  logic [2:0] grant;
  assign grant = (|hi_req) ? lowest(hi_req) : lowest(req);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    cs_d    = cs_q;
    valid_d = valid_q;
    ack_d   = '0;
`ifdef TDM_MUX_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (en && (|req)) begin
          dout_d  = din_arr[grant];
          cs_d    = grant;
          valid_d = 1'b1;
          ack_d   = 8'd1 << grant;
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Word done. dout/cs keep their value; valid alone marks them stale.
          valid_d = 1'b0;
          state_d = S_IDLE;
`ifdef TDM_MUX_RR_EN
          // cs_q still holds the granted channel; 3-bit add wraps 7 -> 0.
          ptr_d   = cs_q + 3'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      cs_q    <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
`ifdef TDM_MUX_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      cs_q    <= cs_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
`ifdef TDM_MUX_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign dout  = dout_q;
  assign cs    = cs_q;
  assign valid = valid_q;
  assign ack   = ack_q;

endmodule

// Per-lane qualifier: flags a request whose index is at or above the
// current scan base.
module fpga_exp2_tdm_mux_lane #(
  parameter int IDX = 0
) (
  input  logic       req_i,
  input  logic [2:0] ptr_i,
  output logic       hi_o
);
  assign hi_o = req_i && (3'(IDX) >= ptr_i);
endmodule

// File: doc/fpga_exp2_tdm_mux.md
# fpga_exp2_tdm_mux

Eight-channel time-division multiplexer, the collecting counterpart of the EXP2 1-to-8 demultiplexer. It arbitrates among eight 4-bit sources and places one word at a time on a shared 4-bit bus, together with its 3-bit channel select. The `dout`/`cs` pair of this block drives the demultiplexer's `data4`/`cs` inputs directly. `valid` qualifies the bus and `ack` returns a one-cycle handshake to the granted source.

## Interface
- `HOLD`, default 2: number of cycles each granted word is held on the bus; legal range 1..15.

- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  global enable; new grants are issued only while high
- `req`  in  8  per-channel request, level-sensitive; bit i belongs to `din`i
- `din0`..`din7`  in  4 each  channel data; sampled only at the grant edge
- `dout`  out  4  multiplexed data word, registered
- `cs`  out  3  channel index of the word on `dout`, registered
- `valid`  out  1  high while `dout`/`cs` carry a granted word
- `ack`  out  8  one-hot grant pulse, exactly one cycle wide

## Operation
- FSM has two states: IDLE and HOLD. A 4-bit hold counter `cnt` and a 3-bit round-robin pointer `ptr` complete the state.
- **IDLE** (`valid`=0, `ack`=0):
  - If `en`=1 and `req`≠0, grant channel g: the first set `req` bit scanning upward from `ptr`, wrapping 7→0.
  - At that edge: `dout`←`din`g, `cs`←g, `valid`←1, `ack`←(1<<g), `cnt`←`HOLD`-1. Next state is HOLD.
  - Otherwise remain in IDLE.
- **HOLD**:
  - `dout`, `cs` and `valid` are stable; `ack` returns to 0 after its first cycle.
  - While `cnt`≠0: `cnt`←`cnt`-1.
  - When `cnt`=0: `valid`←0, `ptr`←g+1 (mod 8). Next state is IDLE.
- `dout` and `cs` keep their last values while in IDLE; only `valid` marks them stale.
- Each grant always leaves exactly one IDLE cycle before the next grant. Maximum throughput is one word per `HOLD`+1 cycles.
- `req` is a level. A source that keeps `req` high after its `ack` is granted again, but only after every other requester has been served (round-robin fairness).
- `en` falling during HOLD does not abort the current word; the block then parks in IDLE.
- `req` changes during HOLD are ignored until the next IDLE evaluation. `din` changes during HOLD do not reach `dout`.

## Timing
- Reset values: `dout`=0, `cs`=0, `valid`=0, `ack`=0, `ptr`=0, `cnt`=0, state IDLE.
- Reset takes effect immediately and independently of `clk`, including mid-HOLD. The word in flight is dropped and no `ack` is reissued for it.
- Latency from `req` sampled high in IDLE to `valid`=1 is one edge. `ack` rises on that same edge.
- `valid` stays high for exactly `HOLD` cycles.
- With `HOLD`=1, `cnt` is loaded with 0 and `valid` drops on the next edge.

## Configuration
- `TDM_MUX_RR_EN` defined: round-robin grant starting from `ptr`, as described above.
- `TDM_MUX_RR_EN` undefined: fixed priority, where the lowest-index set `req` bit wins. `ptr` is not implemented, and all other timing is identical.

## Test plan
- **Reset mid-HOLD:** `HOLD`=4; grant ch2 with `din2`=4'hA, then assert `rst` 2 cycles into HOLD.
  - Expect `dout`/`cs`/`valid`/`ack` all 0 within the same cycle; the next grant scans from ch0.
- **Single request:** `HOLD`=2, `en`=1, `req`=8'h08, `din3`=4'h5.
  - Expect one edge later: `cs`=3, `dout`=5, `ack`=8'h08 for 1 cycle, `valid`=1 for 2 cycles, then one cycle with `valid`=0.
- **Round-robin sweep:** `req`=8'hFF held; `din`i=i+8.
  - Expect `cs` sequence 0,1,…,7,0 with `dout` 8..15, each word separated by one `valid`=0 cycle.
  - Without `TDM_MUX_RR_EN`: `cs` stays 0 throughout.
- **Wrap-around:** grant ch6, then `req`=8'h81.
  - Expect ch7 served next, then ch0.
- **Enable gating:** `en`=0 with `req`=8'h10 → no `valid` and no `ack`. Raise `en` → ch4 granted on the next edge. Drop `en` during HOLD → the word completes its full `HOLD` cycles.
- **End to end:** connect to the EXP2 demultiplexer with `req`=8'h24, `din2`=4'h3, `din5`=4'hC.
  - Expect the demultiplexer's `dout2`=3, then `dout5`=C.
